// File: rtl/spi_master_ctrl_pkg.sv
// Shared definitions for the SPI master transaction engine.
// Frame states, the SPI mode constant and a small width helper.
package spi_master_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  // {CPOL, CPHA}; the engine implements mode 0 only
  localparam logic [1:0] SPI_MODE0 = 2'b00;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_master_ctrl_clk_div.sv
// spi_clk_div: sclk half-period divider for the SPI master.
// While en is high, emits a one-cycle strobe at the end of every CLK_DIV
// cycles, alternating rise_tick / fall_tick starting with a rise.
// Counter and phase restart whenever en is low.
module spi_clk_div
  import spi_master_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lvl_q, lvl_d;
  logic             tick;

  // down-counter with terminal-count tick; lvl tracks which edge comes next
  always_comb begin
    cnt_d     = cnt_q;
    lvl_d     = lvl_q;
    tick      = en && (cnt_q == '0);
    if (!en) begin
      cnt_d = RELOAD;
      lvl_d = 1'b0;
    end else if (tick) begin
      cnt_d = RELOAD;
      lvl_d = ~lvl_q;
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    rise_tick = tick && !lvl_q;
    fall_tick = tick && lvl_q;
  end

  // divider state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= RELOAD;
      lvl_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI mode-0 master, one DATA_W-bit full-duplex frame per start.
// cs_sel/cs_en feed the slave-select decoder (in/enable).
// Optional macro SPI_LSB_FIRST_EN adds the lsb_first input (latched at start).
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | waiting for start; cs_en low, cs_sel holds last slave
//  ST_SETUP | cs_en high, first bit on mosi, CS_SETUP cycles
//  ST_SHIFT | sclk toggles every CLK_DIV cycles, 2*DATA_W edges
//  ST_HOLD  | sclk/mosi low, cs_en high for CS_HOLD cycles, then done
module spi_master_ctrl
  import spi_master_ctrl_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int SEL_W    = 3,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [SEL_W-1:0]  slave_sel,
`ifdef SPI_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic [SEL_W-1:0]  cs_sel,
  output logic              cs_en,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam int   BC_W      = $clog2(DATA_W + 1);
  localparam int   PH_W      = $clog2(max2(CS_SETUP, CS_HOLD) + 1);
  localparam logic SCLK_IDLE = SPI_MODE0[1];

  state_e            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [SEL_W-1:0]  cs_sel_q, cs_sel_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cs_en_q, cs_en_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              rise_tick, fall_tick;
  logic              lsb_start, lsb_cur;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk       (clk),
    .rst       (rst),
    .en        (state_q == ST_SHIFT),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

`ifdef SPI_LSB_FIRST_EN
  logic lsb_q, lsb_d;
  assign lsb_start = lsb_first;
  assign lsb_cur   = lsb_q;

  // bit order is frozen for the frame at acceptance
  always_comb lsb_d = (state_q == ST_IDLE && start) ? lsb_first : lsb_q;

  // bit-order register
  always_ff @(posedge clk) begin
    if (rst) lsb_q <= 1'b0;
    else     lsb_q <= lsb_d;
  end
`else
  assign lsb_start = 1'b0;
  assign lsb_cur   = 1'b0;
`endif

  // next-state, shift registers and registered outputs
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    cs_sel_d  = cs_sel_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SETUP;
          phase_d   = PH_W'(CS_SETUP - 1);
          bit_cnt_d = BC_W'(DATA_W);
          cs_sel_d  = slave_sel;
          rx_sr_d   = '0;
          // first bit goes straight to mosi; the register holds the rest
          mosi_d    = lsb_start ? tx_data[0] : tx_data[DATA_W-1];
          tx_sr_d   = lsb_start ? (tx_data >> 1) : (tx_data << 1);
        end
      end
      ST_SETUP: begin
        if (phase_q == '0) state_d = ST_SHIFT;
        else               phase_d = phase_q - PH_W'(1);
      end
      ST_SHIFT: begin
        if (rise_tick) begin
          sclk_d  = ~SCLK_IDLE;
          rx_sr_d = lsb_cur ? {miso, rx_sr_q[DATA_W-1:1]}
                            : {rx_sr_q[DATA_W-2:0], miso};
        end
        if (fall_tick) begin
          sclk_d = SCLK_IDLE;
          if (bit_cnt_q == BC_W'(1)) begin
            state_d = ST_HOLD;
            mosi_d  = 1'b0;
            phase_d = PH_W'(CS_HOLD - 1);
          end else begin
            bit_cnt_d = bit_cnt_q - BC_W'(1);
            mosi_d    = lsb_cur ? tx_sr_q[0] : tx_sr_q[DATA_W-1];
            tx_sr_d   = lsb_cur ? (tx_sr_q >> 1) : (tx_sr_q << 1);
          end
        end
      end
      ST_HOLD: begin
        if (phase_q == '0) begin
          state_d   = ST_IDLE;
          done_d    = 1'b1;
          rx_data_d = rx_sr_q;
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d  = (state_d != ST_IDLE);
    cs_en_d = (state_d != ST_IDLE);
  end

  // state and output registers; reset discards any partial frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      bit_cnt_q <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      cs_sel_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cs_en_q   <= 1'b0;
      sclk_q    <= SCLK_IDLE;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      cs_sel_q  <= cs_sel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cs_en_q   <= cs_en_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign cs_sel  = cs_sel_q;
  assign cs_en   = cs_en_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl (DATA_W=8, SEL_W=3, CLK_DIV=2,
// CS_SETUP=2, CS_HOLD=2). Define SPI_LSB_FIRST_EN for the bit-order case.
module tb_spi_master_ctrl;

  localparam int DATA_W    = 8;
  localparam int SEL_W     = 3;
  localparam int CLK_DIV   = 2;
  localparam int CS_SETUP  = 2;
  localparam int CS_HOLD   = 2;
  localparam int SHIFT_END = CS_SETUP + 2 * CLK_DIV * DATA_W;  // 34
  localparam int FRAME     = SHIFT_END + CS_HOLD;             // 36
  localparam int BUDGET    = FRAME + 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [DATA_W-1:0] tx_data = '0;
  logic [SEL_W-1:0]  slave_sel = '0;
  logic              busy, done, cs_en, sclk, mosi, miso;
  logic [DATA_W-1:0] rx_data;
  logic [SEL_W-1:0]  cs_sel;
  logic              loop_en = 1'b1;
  logic              miso_fix = 1'b0;
`ifdef SPI_LSB_FIRST_EN
  logic              lsb_first = 1'b0;
`endif

  assign miso = loop_en ? mosi : miso_fix;

  spi_master_ctrl #(
    .DATA_W(DATA_W), .SEL_W(SEL_W), .CLK_DIV(CLK_DIV),
    .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .tx_data   (tx_data),
    .slave_sel (slave_sel),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first (lsb_first),
`endif
    .busy      (busy),
    .done      (done),
    .rx_data   (rx_data),
    .cs_sel    (cs_sel),
    .cs_en     (cs_en),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int              en_cnt, done_cnt, done_at, rises, quiet_bad;
  logic [7:0]      mosi_bits, dec_mid;
  logic [SEL_W-1:0] sel_mid;
  logic            sclk_prev;

  function automatic logic [7:0] dec8(input logic [2:0] sel, input logic en);
    return en ? (8'd1 << sel) : 8'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic launch(input logic [7:0] tx, input logic [2:0] sel);
    tx_data   = tx;
    slave_sel = sel;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  // c = number of edges after the accepting edge; pulse_at injects a start
  task automatic observe(input int pulse_at);
    en_cnt = 0; done_cnt = 0; done_at = -1; rises = 0; quiet_bad = 0;
    mosi_bits = '0; sclk_prev = 1'b0; dec_mid = '0; sel_mid = '0;
    for (int c = 0; c < BUDGET; c++) begin
      if (cs_en) en_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (sclk && !sclk_prev) begin
        rises++;
        mosi_bits = {mosi_bits[6:0], mosi};
      end
      sclk_prev = sclk;
      if (c < CS_SETUP && sclk) quiet_bad++;
      if (c >= SHIFT_END && c < FRAME && (sclk || mosi)) quiet_bad++;
      if (c == 20) begin
        sel_mid = cs_sel;
        dec_mid = dec8(cs_sel, cs_en);
      end
      if (c == 3) begin
        tx_data   = 8'h3C;
        slave_sel = ~slave_sel;
      end
      if (c == pulse_at) begin
        tx_data = 8'hFF;
        start   = 1'b1;
      end
      if (c == pulse_at + 1) start = 1'b0;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_at;
    int dn;

    // reset state
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_busy",  busy,    0);
    check("rst_done",  done,    0);
    check("rst_cs_en", cs_en,   0);
    check("rst_sclk",  sclk,    0);
    check("rst_mosi",  mosi,    0);
    check("rst_rx",    rx_data, 0);
    check("rst_cssel", cs_sel,  0);

    // frame 1: loopback 0xA5 to slave 5
    launch(8'hA5, 3'd5);
    check("f1_busy", busy, 1);
    check("f1_mosi_first", mosi, 1);
    observe(-1);
    check("f1_en_cycles", en_cnt, 36);
    check("f1_done_at", done_at, FRAME);
    check("f1_done_cnt", done_cnt, 1);
    check("f1_mosi_bits", mosi_bits, 8'hA5);
    check("f1_rx", rx_data, 8'hA5);
    check("f1_cs_sel", sel_mid, 5);
    check("f1_quiet", quiet_bad, 0);
    check("f1_idle_cssel", cs_sel, 5);
    check("f1_idle_busy", busy, 0);

    // frame 2: miso tied high, tx 0x00
    loop_en  = 1'b0;
    miso_fix = 1'b1;
    launch(8'h00, 3'd1);
    observe(-1);
    check("f2_rx", rx_data, 8'hFF);
    check("f2_rises", rises, 8);
    check("f2_quiet", quiet_bad, 0);
    check("f2_mosi_bits", mosi_bits, 8'h00);
    loop_en = 1'b1;

    // frame 3: start during busy is ignored
    launch(8'h69, 3'd3);
    observe(10);
    check("f3_done_cnt", done_cnt, 1);
    check("f3_rx", rx_data, 8'h69);
    check("f3_busy_after", busy, 0);

    // frame 4/5: back-to-back via start in the done cycle
    launch(8'h5A, 3'd2);
    wait_at = -1;
    for (int c = 0; c < BUDGET; c++) begin
      if (done) begin
        wait_at = c;
        break;
      end
      step();
    end
    check("b2b_done_at", wait_at, FRAME);
    check("b2b_gap_en", cs_en, 0);
    check("b2b_rx1", rx_data, 8'h5A);
    tx_data   = 8'hC3;
    slave_sel = 3'd6;
    start     = 1'b1;
    step();
    start = 1'b0;
    check("b2b_restart_en", cs_en, 1);
    check("b2b_restart_busy", busy, 1);
    observe(-1);
    check("b2b_done_at2", done_at, FRAME);
    check("b2b_rx2", rx_data, 8'hC3);
    check("b2b_cs_sel", sel_mid, 6);

    // reset mid-SHIFT discards the frame
    launch(8'h96, 3'd4);
    repeat (15) step();
    check("mid_busy_pre", busy, 1);
    rst = 1'b1;
    step();
    check("mid_busy",  busy,    0);
    check("mid_cs_en", cs_en,   0);
    check("mid_sclk",  sclk,    0);
    check("mid_mosi",  mosi,    0);
    check("mid_rx",    rx_data, 0);
    check("mid_done",  done,    0);
    rst = 1'b0;
    dn = 0;
    for (int c = 0; c < BUDGET; c++) begin
      if (done) dn++;
      step();
    end
    check("mid_no_done", dn, 0);
    launch(8'h3E, 3'd1);
    observe(-1);
    check("post_done_at", done_at, FRAME);
    check("post_rx", rx_data, 8'h3E);

    // decoder chain: one-hot only while cs_en, zero in idle
    for (int s = 0; s < 8; s++) begin
      launch(8'(s * 17), 3'(s));
      observe(-1);
      check($sformatf("dec_active_%0d", s), dec_mid, 8'd1 << s);
      check($sformatf("dec_idle_%0d", s), dec8(cs_sel, cs_en), 8'd0);
    end

`ifdef SPI_LSB_FIRST_EN
    lsb_first = 1'b1;
    launch(8'h01, 3'd0);
    lsb_first = 1'b0;
    observe(-1);
    check("lsb_mosi_bits", mosi_bits, 8'h80);
    check("lsb_rx", rx_data, 8'h01);
    lsb_first = 1'b1;
    launch(8'hB4, 3'd2);
    lsb_first = 1'b0;
    observe(-1);
    check("lsb_mosi_bits2", mosi_bits, 8'h2D);
    check("lsb_rx2", rx_data, 8'hB4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
